alu_proj: RTL and testbench

- 16-bit, 4-function arithmetic/logic unit with carry-in and carry-out.
- Operands, opcode and carry-in are combinationally evaluated; the result and carry-out are registered on the rising clock edge.
- Leaf datapath block used wherever a simple registered ALU stage is needed; no handshake, one result per cycle.

---
 rtl/alu_proj.sv | 99 +++++++++
 tb/tb_alu_proj.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_proj.sv
// -----------------------------------------------------------------------------
// alu_proj -- registered 4-function ALU stage with carry-in / carry-out.
//
// Operands, opcode and carry-in are evaluated combinationally. The result and
// the carry/borrow are captured on the rising edge of clk. This gives a fixed
// latency of one cycle and accepts a new operation every cycle.
//
// There is no handshake. Every rising edge consumes whatever is on the inputs
// and replaces the previous result, so there is no valid/ready pair to honour.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset; clears out/carryout
//   a         in   WIDTH  operand A (unsigned)
//   b         in   WIDTH  operand B (unsigned)
//   opcode    in   2      00 ADD, 01 OR, 10 SUB, 11 XOR
//   ci        in   1      carry-in (ADD) / borrow-in (SUB); ignored otherwise
//   out       out  WIDTH  registered result
//   carryout  out  1      registered carry (ADD) / borrow (SUB); 0 for logic ops
// -----------------------------------------------------------------------------
module alu_proj #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  input  logic             ci,
  output logic [WIDTH-1:0] out,
  output logic             carryout
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_co;

  logic [WIDTH-1:0] r_out;
  logic             r_co;

  // Both arithmetic paths are computed at WIDTH+1 bits.
  // The subtraction is done in two's complement, and its true value lies in
  // [-(2^WIDTH), 2^WIDTH-1]. Bit WIDTH of the (WIDTH+1)-bit difference is
  // therefore set exactly when a < b + ci, which is the unsigned borrow.
  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
  end

  // Result select. The four codes form a full case for synthesis. An X/Z
  // opcode in simulation drives X rather than aliasing to a legal operation.
  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_co  = w_sum[WIDTH];
      end
      OP_OR: begin
        w_res = a | b;
        w_co  = 1'b0;
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_co  = w_diff[WIDTH];
      end
      OP_XOR: begin
        w_res = a ^ b;
        w_co  = 1'b0;
      end
      default: begin
        w_res = {WIDTH{1'bx}};
        w_co  = 1'bx;
      end
    endcase
  end

  // Output registers. Reset wins over any operation presented that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_co  <= 1'b0;
    end else begin
      r_out <= w_res;
      r_co  <= w_co;
    end
  end

  assign out      = r_out;
  assign carryout = r_co;

endmodule

// File: tb/tb_alu_proj.sv
// -----------------------------------------------------------------------------
// tb_alu_proj -- self-checking bench for alu_proj.
// Directed vectors (reset, ADD/OR/SUB/XOR, boundaries, back-to-back stream with
// a mid-stream reset) followed by random traffic, all scored against a
// behavioural model that works in plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_proj;

  localparam int WIDTH = 16;
  localparam longint MOD = 64'd1 << WIDTH;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       opcode = 2'b00;
  logic             ci = 1'b0;
  logic [WIDTH-1:0] out;
  logic             carryout;

  always #5 clk = ~clk;

  alu_proj #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .ci       (ci),
    .out      (out),
    .carryout (carryout)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];   // {carry, result}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic over the opcode map, no bit tricks.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic [1:0] mop, input logic mci, input logic mrst);
    longint va, vb, vc, s;
    logic [WIDTH-1:0] r;
    logic c;
    va = longint'(ma);
    vb = longint'(mb);
    vc = mci ? 64'sd1 : 64'sd0;
    r = '0;
    c = 1'b0;
    if (mrst) return '0;
    case (mop)
      2'd0: begin
        s = va + vb + vc;
        r = WIDTH'(s % MOD);
        c = (s >= MOD);
      end
      2'd1: r = ma | mb;
      2'd2: begin
        s = va - vb - vc;
        c = (s < 0);
        r = WIDTH'((s + MOD) % MOD);
      end
      default: r = ma ^ mb;
    endcase
    return {c, r};
  endfunction

  // ---------------- driver ----------------
  // Present one operation, let one edge pass, then score the registered result.
  task automatic apply(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [1:0] top, input logic tci, input logic trst);
    logic [WIDTH:0] e;
    a = ta;
    b = tb_;
    opcode = top;
    ci = tci;
    rst = trst;
    exp_q.push_back(model(ta, tb_, top, tci, trst));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_out"}, 32'(out), 32'(e[WIDTH-1:0]));
    check({tag, "_co"}, 32'(carryout), 32'(e[WIDTH]));
  endtask

  // Known-answer check, independent of the model.
  task automatic kat(input string tag, input logic [WIDTH-1:0] eo, input logic ec);
    check({tag, "_kat_out"}, 32'(out), 32'(eo));
    check({tag, "_kat_co"}, 32'(carryout), 32'(ec));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with inputs that would otherwise carry out.
    apply("rst0", 16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 1'b1);
    kat("rst0", 16'h0000, 1'b0);
    apply("rst1", 16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 1'b1);
    kat("rst1", 16'h0000, 1'b0);
    apply("rel", 16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 1'b0);
    kat("rel", 16'hFFFF, 1'b1);

    apply("add_c0", 16'hC08D, 16'h8002, 2'b00, 1'b0, 1'b0);
    kat("add_c0", 16'h408F, 1'b1);
    apply("add_c1", 16'hC08D, 16'h8002, 2'b00, 1'b1, 1'b0);
    kat("add_c1", 16'h4090, 1'b1);
    apply("add_wrap", 16'hFFFF, 16'h0000, 2'b00, 1'b1, 1'b0);
    kat("add_wrap", 16'h0000, 1'b1);
    apply("or_c0", 16'h002A, 16'h0015, 2'b01, 1'b0, 1'b0);
    kat("or_c0", 16'h003F, 1'b0);
    apply("or_c1", 16'h002A, 16'h0015, 2'b01, 1'b1, 1'b0);
    kat("or_c1", 16'h003F, 1'b0);
    apply("sub_eq", 16'h0025, 16'h0025, 2'b10, 1'b0, 1'b0);
    kat("sub_eq", 16'h0000, 1'b0);
    apply("sub_uf", 16'h0000, 16'h0001, 2'b10, 1'b0, 1'b0);
    kat("sub_uf", 16'hFFFF, 1'b1);
    apply("sub_zb", 16'h0000, 16'h0000, 2'b10, 1'b1, 1'b0);
    kat("sub_zb", 16'hFFFF, 1'b1);
    apply("sub_big", 16'h0005, 16'h0003, 2'b10, 1'b1, 1'b0);
    kat("sub_big", 16'h0001, 1'b0);
    apply("xor", 16'h5CAB, 16'hEB57, 2'b11, 1'b0, 1'b0);
    kat("xor", 16'hB7FC, 1'b0);

    // Back-to-back stream with a one-cycle reset in the middle.
    apply("s_add", 16'hC08D, 16'h8002, 2'b00, 1'b0, 1'b0);
    kat("s_add", 16'h408F, 1'b1);
    apply("s_or", 16'h002A, 16'h0015, 2'b01, 1'b0, 1'b0);
    kat("s_or", 16'h003F, 1'b0);
    apply("s_rst", 16'h0000, 16'h0001, 2'b10, 1'b0, 1'b1);
    kat("s_rst", 16'h0000, 1'b0);
    apply("s_sub", 16'h0000, 16'h0001, 2'b10, 1'b0, 1'b0);
    kat("s_sub", 16'hFFFF, 1'b1);
    apply("s_xor", 16'h5CAB, 16'hEB57, 2'b11, 1'b0, 1'b0);
    kat("s_xor", 16'hB7FC, 1'b0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 12000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic [1:0] rop;
      logic rci, rrst;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      // Bias some operands to the extremes so carries and borrows at the edges show up.
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 1) ? '1 : '0;
      if ($urandom_range(0, 7) == 0) rb = $urandom_range(0, 1) ? '1 : '0;
      if ($urandom_range(0, 15) == 0) rb = ra;
      rop  = 2'($urandom_range(0, 3));
      rci  = 1'($urandom_range(0, 1));
      rrst = ($urandom_range(0, 99) == 0);
      apply("rand", ra, rb, rop, rci, rrst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
